// File: rtl/calc_pkg.sv
// Shared constants and helpers for the elastic pipeline: default geometry and
// the width of the occupancy counter.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;

  // Bits needed to represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One slot of the elastic pipeline: a valid flag plus a payload register that
// loads from its upstream source and holds otherwise.
module elastic_stage
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] src,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would ripple a word through
  // several stages in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      // NOTE: the payload is reset as well because out_data is observable and
      // must read zero after reset, not whatever was captured before.
      data  <= '0;
    end else begin
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (drain) valid <= 1'b0;

      // Payload survives a flush; only the valid flags are cleared.
      if (load && !flush) data <= src;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic valid/ready pipeline of DEPTH register stages with bubble compression,
// synchronous flush and a registered occupancy count.
module elastic_pipe
  import calc_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   ready;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] drain;
  logic             in_xfer;
  logic             out_xfer;

  // ready[k]: stage k can take a word, i.e. it is empty or everything in front
  // of it moves this cycle. ready[DEPTH] is the downstream sink.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = !v[k] || ready[k + 1];
    end
  end

  assign in_ready = rst_n && !flush && ready[0];
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = v[DEPTH-1] && out_ready;

  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = v[k - 1] && ready[k];
    end
  end

  // A stage empties when its word is taken by the next stage or the sink.
  assign drain = v & ready[DEPTH:1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src;

    if (k == 0) begin : g_head
      assign src = in_data;
    end else begin : g_body
      assign src = d[k - 1];
    end

    elastic_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .load  (load[k]),
      .drain (drain[k]),
      .src   (src),
      .valid (v[k]),
      .data  (d[k])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Tracking transfers keeps count equal to the population of v[].
  always_ff @(posedge clk) begin
    if (!rst_n)     count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(in_xfer) - CW'(out_xfer);
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: three geometries, each with a queue-based positional
// model compared every cycle, plus directed literal checks on the default one.
module tb_elastic_pipe;

  typedef struct {
    logic [31:0] data;
    int          pos;
  } ent_t;

  localparam int NCFG = 3;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = (g == 0) ? 8 : (g == 1) ? 1 : 16;
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int CW = $clog2(D + 1);

    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    bit            done   = 1'b0;
    bit            chk_en = 1'b0;

    elastic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
    );

    // Model: ordered list of held words, each with the stage index it occupies.
    ent_t        q[$];
    logic [31:0] last_out = '0;

    function automatic bit m_out_valid();
      return (q.size() > 0) && (q[0].pos == D - 1);
    endfunction

    function automatic bit m_in_ready();
      return rst_n && !flush && ((q.size() < D) || out_ready);
    endfunction

    always @(posedge clk) begin
      bit   ix, ox;
      int   lim, np;
      ent_t e;
      ix = in_valid && m_in_ready();
      ox = m_out_valid() && out_ready;
      if (!rst_n) begin
        q.delete();
        last_out = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        if (ox) void'(q.pop_front());
        lim = D;
        foreach (q[i]) begin
          np = (q[i].pos + 1 < lim - 1) ? q[i].pos + 1 : lim - 1;
          if (np == D - 1 && q[i].pos != D - 1) last_out = q[i].data;
          q[i].pos = np;
          lim = np;
        end
        if (ix) begin
          e.data = 32'(in_data);
          e.pos  = 0;
          if (D == 1) last_out = e.data;
          q.push_back(e);
        end
      end
      chk_en = 1'b1;
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("cfg%0d in_ready", g),  32'(in_ready),  32'(m_in_ready()));
        check($sformatf("cfg%0d out_valid", g), 32'(out_valid), 32'(m_out_valid()));
        check($sformatf("cfg%0d out_data", g),  32'(out_data),  last_out);
        check($sformatf("cfg%0d count", g),     32'(count),     32'(q.size()));
        check($sformatf("cfg%0d count_range", g), 32'(count <= CW'(D)), 32'd1);
      end
    end

    task automatic set_in(input logic rst, input logic v, input logic [31:0] dat,
                          input logic rdy, input logic fl);
      #1;
      rst_n     = rst;
      in_valid  = v;
      in_data   = dat[W-1:0];
      out_ready = rdy;
      flush     = fl;
      #1;
    endtask

    task automatic tick();
      @(posedge clk);
      @(negedge clk);
    endtask

    task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
        set_in($urandom_range(0, 149) != 0, $urandom_range(0, 3) != 0, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        tick();
      end
    endtask

    if (g == 0) begin : g_directed
      initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        // Reset held two edges with a live input.
        set_in(1'b0, 1'b1, 32'hFF, 1'b0, 1'b0);
        tick(); tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data",  32'(out_data),  32'h00);
        check("rst count",     32'(count),     32'd0);
        check("rst in_ready",  32'(in_ready),  32'd0);

        // Streaming 01..05 with the sink always ready.
        for (int k = 1; k <= 7; k++) begin
          set_in(1'b1, k <= 5, 32'(k), 1'b1, 1'b0);
          if (k <= 5) check("stream in_ready", 32'(in_ready), 32'd1);
          tick();
          check("stream out_valid", 32'(out_valid), 32'((k >= 2) && (k <= 6)));
          if (k >= 2 && k <= 6) check("stream out_data", 32'(out_data), 32'(k - 1));
          check("stream count", 32'(count), (k == 1) ? 32'd1 : (k <= 5) ? 32'd2 : (k == 6) ? 32'd1 : 32'd0);
        end

        // Stall until full, then simultaneous push/pop, then drain.
        set_in(1'b1, 1'b1, 32'hA1, 1'b0, 1'b0);
        check("stall in_ready A1", 32'(in_ready), 32'd1);
        tick();
        set_in(1'b1, 1'b1, 32'hA2, 1'b0, 1'b0);
        check("stall in_ready A2", 32'(in_ready), 32'd1);
        tick();
        set_in(1'b1, 1'b1, 32'hA3, 1'b0, 1'b0);
        check("full in_ready", 32'(in_ready), 32'd0);
        check("full count",    32'(count),    32'd2);
        check("full out_data", 32'(out_data), 32'hA1);
        tick();
        check("stall hold out_data", 32'(out_data), 32'hA1);
        check("stall hold count",    32'(count),    32'd2);
        set_in(1'b1, 1'b1, 32'hA3, 1'b1, 1'b0);
        check("pushpop in_ready", 32'(in_ready), 32'd1);
        tick();
        check("pushpop count",    32'(count),    32'd2);
        check("pushpop out_data", 32'(out_data), 32'hA2);
        set_in(1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
        tick();
        check("drain out_data A3", 32'(out_data), 32'hA3);
        check("drain count 1",     32'(count),    32'd1);
        tick();
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain count 0",   32'(count),      32'd0);

        // Flush while holding 11,22 with 33 offered.
        set_in(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
        tick();
        check("preflush count", 32'(count), 32'd2);
        set_in(1'b1, 1'b1, 32'h33, 1'b1, 1'b1);
        check("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        check("flush count",     32'(count),     32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        set_in(1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
        tick(); tick();
        check("postflush out_valid", 32'(out_valid), 32'd0);
        check("postflush out_data",  32'(out_data),  32'h11);

        // Reset mid-stream, then first word follows normal latency.
        set_in(1'b1, 1'b1, 32'h44, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 32'h45, 1'b0, 1'b0);
        tick();
        check("midrst count", 32'(count), 32'd0);
        set_in(1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
        tick();
        check("midrst lat out_valid", 32'(out_valid), 32'd0);
        set_in(1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
        tick();
        check("midrst lat out_data", 32'(out_data), 32'h55);

        random_phase(2000);
        done = 1'b1;
      end
    end else begin : g_random
      initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        set_in(1'b0, 1'b1, 32'hFFFF, 1'b0, 1'b0);
        tick(); tick();
        random_phase(2000);
        done = 1'b1;
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 20000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done;
    end
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL timeout: stimulus did not complete, got not-done, expected done");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
